id_ex_stage: RTL and testbench

- Pipeline register between Decode and the combined Execute/Memory stage. It feeds SrcA, WriteData, ImmExt, ALUControl, funct3, MemWrite and ALUSrc into that stage.
- Resolves RAW hazards by forwarding the Writeback-stage result, both into the captured operands and onto the outgoing operands.
- Supports a downstream hold (stall) and a flush (branch kill).
- No stall generation is needed, because a load's data is available in Writeback exactly one instruction later.

---
 rtl/id_ex_stage.sv | 216 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - Decode to Execute/Memory pipeline register with Writeback forwarding
//
// Purpose:
//   Captures one decoded instruction per cycle and presents its operands and
//   controls to the combined Execute/Memory stage one cycle later. RAW hazards
//   are resolved by forwarding the Writeback result at two points. The first is
//   at capture, which covers a register-file write and read in the same cycle.
//   The second is on the outgoing operands, which covers a producer that is one
//   instruction ahead. Supports hold (stall from downstream) and flush (branch kill).
//
// Optional feature:
//   ID_EX_PERF_EN - adds perf_bubbles / perf_holds event counters.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                decoded instruction fields from Decode
//   hold, flush         downstream stall, pipeline kill (flush wins)
//   wb_reg_write/rd/result  Writeback register-file write port (forwarding source)
//   SrcA, WriteData     forwarded operands A / B
//   ImmExt, ALUControl, funct3, ALUSrc, MemWrite  Execute/Memory controls
//   ex_valid, ex_reg_write, ex_mem_to_reg, ex_rd  instruction status to later stages
//   fwd_a, fwd_b        outgoing operand is taken from Writeback this cycle
//   perf_bubbles, perf_holds  (ID_EX_PERF_EN only) event counters

module id_ex_stage #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic [XLEN-1:0]   id_rs1_val,
   input  logic [XLEN-1:0]   id_rs2_val,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [2:0]        id_alu_ctrl,
   input  logic [2:0]        id_funct3,
   input  logic              id_mem_write,
   input  logic              id_alu_src,
   input  logic              id_reg_write,
   input  logic              id_mem_to_reg,
   input  logic              hold,
   input  logic              flush,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_result,
   output logic [XLEN-1:0]   SrcA,
   output logic [XLEN-1:0]   WriteData,
   output logic [XLEN-1:0]   ImmExt,
   output logic [2:0]        ALUControl,
   output logic [2:0]        funct3,
   output logic              ALUSrc,
   output logic              MemWrite,
   output logic              ex_valid,
   output logic              ex_reg_write,
   output logic              ex_mem_to_reg,
   output logic [REG_AW-1:0] ex_rd,
   output logic              fwd_a,
   output logic              fwd_b
`ifdef ID_EX_PERF_EN
   ,
   output logic [31:0]       perf_bubbles,
   output logic [31:0]       perf_holds
`endif
);

   logic              valid_q, valid_d;
   logic              reg_write_q, reg_write_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              mem_write_q, mem_write_d;
   logic              alu_src_q, alu_src_d;
   logic [2:0]        alu_ctrl_q, alu_ctrl_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [REG_AW-1:0] rs1_q, rs1_d;
   logic [REG_AW-1:0] rs2_q, rs2_d;
   logic [XLEN-1:0]   rs1_val_q, rs1_val_d;
   logic [XLEN-1:0]   rs2_val_q, rs2_val_d;
   logic [XLEN-1:0]   imm_q, imm_d;

   logic match_ex_rs1, match_ex_rs2, match_id_rs1, match_id_rs2;
   logic load_bubble;

   // x0 is hard-wired zero, so a write to it must never be forwarded.
   always_comb begin
      match_ex_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q);
      match_ex_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q);
      match_id_rs1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
      match_id_rs2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);
   end

   assign load_bubble = flush || (!hold && !id_valid);

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      mem_write_d  = mem_write_q;
      alu_src_d    = alu_src_q;
      alu_ctrl_d   = alu_ctrl_q;
      funct3_d     = funct3_q;
      rd_d         = rd_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      rs1_val_d    = rs1_val_q;
      rs2_val_d    = rs2_val_q;
      imm_d        = imm_q;
      if (load_bubble) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         mem_to_reg_d = 1'b0;
         mem_write_d  = 1'b0;
         alu_src_d    = 1'b0;
         alu_ctrl_d   = '0;
         funct3_d     = '0;
         rd_d         = '0;
         rs1_d        = '0;
         rs2_d        = '0;
         rs1_val_d    = '0;
         rs2_val_d    = '0;
         imm_d        = '0;
      end else if (hold) begin
         // The producer may leave Writeback while we stall, so latch its value now.
         if (match_ex_rs1) rs1_val_d = wb_result;
         if (match_ex_rs2) rs2_val_d = wb_result;
      end else begin
         valid_d      = 1'b1;
         reg_write_d  = id_reg_write;
         mem_to_reg_d = id_mem_to_reg;
         mem_write_d  = id_mem_write;
         alu_src_d    = id_alu_src;
         alu_ctrl_d   = id_alu_ctrl;
         funct3_d     = id_funct3;
         rd_d         = id_rd;
         rs1_d        = id_rs1;
         rs2_d        = id_rs2;
         // Register file read in the same cycle as its write returns stale data.
         rs1_val_d    = match_id_rs1 ? wb_result : id_rs1_val;
         rs2_val_d    = match_id_rs2 ? wb_result : id_rs2_val;
         imm_d        = id_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_ctrl_q   <= '0;
         funct3_q     <= '0;
         rd_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         rs1_val_q    <= '0;
         rs2_val_q    <= '0;
         imm_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         mem_write_q  <= mem_write_d;
         alu_src_q    <= alu_src_d;
         alu_ctrl_q   <= alu_ctrl_d;
         funct3_q     <= funct3_d;
         rd_q         <= rd_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         rs1_val_q    <= rs1_val_d;
         rs2_val_q    <= rs2_val_d;
         imm_q        <= imm_d;
      end
   end

   // Forward onto both operands regardless of ALUSrc: WriteData also feeds stores.
   assign SrcA          = match_ex_rs1 ? wb_result : rs1_val_q;
   assign WriteData     = match_ex_rs2 ? wb_result : rs2_val_q;
   assign fwd_a         = match_ex_rs1 && valid_q;
   assign fwd_b         = match_ex_rs2 && valid_q;
   assign ImmExt        = imm_q;
   assign ALUControl    = alu_ctrl_q;
   assign funct3        = funct3_q;
   assign ALUSrc        = alu_src_q;
   assign MemWrite      = mem_write_q && valid_q;
   assign ex_valid      = valid_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_to_reg = mem_to_reg_q;
   assign ex_rd         = rd_q;

`ifdef ID_EX_PERF_EN
   logic [31:0] perf_bubbles_q, perf_bubbles_d;
   logic [31:0] perf_holds_q, perf_holds_d;

   always_comb begin
      perf_bubbles_d = perf_bubbles_q + {31'd0, load_bubble};
      perf_holds_d   = perf_holds_q + {31'd0, (hold && !flush)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_bubbles_q <= '0;
         perf_holds_q   <= '0;
      end else begin
         perf_bubbles_q <= perf_bubbles_d;
         perf_holds_q   <= perf_holds_d;
      end
   end

   assign perf_bubbles = perf_bubbles_q;
   assign perf_holds   = perf_holds_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed vector bench for id_ex_stage
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_val, id_rs2_val, id_imm;
   logic [2:0]  id_alu_ctrl, id_funct3;
   logic        id_mem_write, id_alu_src, id_reg_write, id_mem_to_reg;
   logic        hold, flush;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic [31:0] SrcA, WriteData, ImmExt;
   logic [2:0]  ALUControl, funct3;
   logic        ALUSrc, MemWrite, ex_valid, ex_reg_write, ex_mem_to_reg;
   logic [4:0]  ex_rd;
   logic        fwd_a, fwd_b;
`ifdef ID_EX_PERF_EN
   logic [31:0] perf_bubbles, perf_holds;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
      .id_alu_ctrl(id_alu_ctrl), .id_funct3(id_funct3),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
      .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
      .hold(hold), .flush(flush),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .SrcA(SrcA), .WriteData(WriteData), .ImmExt(ImmExt),
      .ALUControl(ALUControl), .funct3(funct3), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
      .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
      .ex_rd(ex_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
`ifdef ID_EX_PERF_EN
      , .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
`endif
   );

   typedef struct {
      logic fl, hd, iv;
      logic [4:0] rs1, rs2, rd;
      logic [31:0] v1, v2, imm;
      logic [2:0] alu, f3;
      logic mw, as, rw, m2r;
      logic wbw;
      logic [4:0] wbrd;
      logic [31:0] wbres;
      logic [31:0] e_srca, e_wd, e_imm;
      logic [2:0] e_alu, e_f3;
      logic e_as, e_mw, e_valid, e_rw, e_m2r;
      logic [4:0] e_rd;
      logic e_fa, e_fb;
   } vec_t;

   vec_t v[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      flush = t.fl; hold = t.hd; id_valid = t.iv;
      id_rs1 = t.rs1; id_rs2 = t.rs2; id_rd = t.rd;
      id_rs1_val = t.v1; id_rs2_val = t.v2; id_imm = t.imm;
      id_alu_ctrl = t.alu; id_funct3 = t.f3;
      id_mem_write = t.mw; id_alu_src = t.as; id_reg_write = t.rw; id_mem_to_reg = t.m2r;
      wb_reg_write = t.wbw; wb_rd = t.wbrd; wb_result = t.wbres;
   endtask

   initial begin
      // Each row: inputs for this cycle, then outputs expected during this cycle
      // (registers from the previous edge combined with this cycle's wb_* inputs).
      v[0]  = '{1'b0,1'b0,1'b1, 5'd1,5'd2,5'd5, 32'h100,32'h200,32'h10, 3'd2,3'd2, 1'b0,1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0,
                32'h0,32'h0,32'h0, 3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0};
      v[1]  = '{1'b0,1'b0,1'b1, 5'd5,5'd3,5'd6, 32'h0,32'h33,32'h20, 3'd1,3'd0, 1'b0,1'b0,1'b1,1'b0, 1'b0,5'd0,32'h0,
                32'h100,32'h200,32'h10, 3'd2,3'd2, 1'b1,1'b0,1'b1,1'b1,1'b0, 5'd5, 1'b0,1'b0};
      v[2]  = '{1'b0,1'b0,1'b1, 5'd4,5'd9,5'd10, 32'hA,32'hB,32'h30, 3'd3,3'd1, 1'b0,1'b0,1'b1,1'b1, 1'b1,5'd5,32'h11,
                32'h11,32'h33,32'h20, 3'd1,3'd0, 1'b0,1'b0,1'b1,1'b1,1'b0, 5'd6, 1'b1,1'b0};
      v[3]  = '{1'b0,1'b0,1'b1, 5'd0,5'd7,5'd0, 32'h5,32'h0,32'hFFFFFFF0, 3'd0,3'd2, 1'b1,1'b1,1'b0,1'b0, 1'b1,5'd7,32'hDEADBEEF,
                32'hA,32'hB,32'h30, 3'd3,3'd1, 1'b0,1'b0,1'b1,1'b1,1'b1, 5'd10, 1'b0,1'b0};
      v[4]  = '{1'b0,1'b0,1'b0, 5'd1,5'd1,5'd1, 32'h1,32'h1,32'h1, 3'd7,3'd7, 1'b1,1'b1,1'b1,1'b1, 1'b0,5'd7,32'h12345678,
                32'h5,32'hDEADBEEF,32'hFFFFFFF0, 3'd0,3'd2, 1'b1,1'b1,1'b1,1'b0,1'b0, 5'd0, 1'b0,1'b0};
      v[5]  = '{1'b0,1'b0,1'b1, 5'd0,5'd0,5'd3, 32'h0,32'h0,32'h0, 3'd0,3'd0, 1'b0,1'b0,1'b1,1'b0, 1'b1,5'd0,32'hFFFFFFFF,
                32'h0,32'h0,32'h0, 3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0};
      v[6]  = '{1'b0,1'b0,1'b1, 5'd3,5'd4,5'd11, 32'h1,32'h2,32'h40, 3'd4,3'd0, 1'b0,1'b0,1'b1,1'b0, 1'b1,5'd0,32'hFFFFFFFF,
                32'h0,32'h0,32'h0, 3'd0,3'd0, 1'b0,1'b0,1'b1,1'b1,1'b0, 5'd3, 1'b0,1'b0};
      v[7]  = '{1'b0,1'b1,1'b1, 5'd9,5'd1,5'd12, 32'h99,32'h77,32'h50, 3'd5,3'd1, 1'b1,1'b1,1'b1,1'b1, 1'b1,5'd3,32'h44,
                32'h44,32'h2,32'h40, 3'd4,3'd0, 1'b0,1'b0,1'b1,1'b1,1'b0, 5'd11, 1'b1,1'b0};
      v[8]  = '{1'b0,1'b1,1'b1, 5'd9,5'd1,5'd12, 32'h99,32'h77,32'h50, 3'd5,3'd1, 1'b1,1'b1,1'b1,1'b1, 1'b0,5'd3,32'h55,
                32'h44,32'h2,32'h40, 3'd4,3'd0, 1'b0,1'b0,1'b1,1'b1,1'b0, 5'd11, 1'b0,1'b0};
      v[9]  = '{1'b1,1'b1,1'b1, 5'd9,5'd1,5'd12, 32'h99,32'h77,32'h50, 3'd5,3'd1, 1'b1,1'b1,1'b1,1'b1, 1'b0,5'd0,32'h0,
                32'h44,32'h2,32'h40, 3'd4,3'd0, 1'b0,1'b0,1'b1,1'b1,1'b0, 5'd11, 1'b0,1'b0};
      v[10] = '{1'b0,1'b0,1'b0, 5'd0,5'd0,5'd0, 32'h0,32'h0,32'h0, 3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0, 1'b0,5'd0,32'h0,
                32'h0,32'h0,32'h0, 3'd0,3'd0, 1'b0,1'b0,1'b0,1'b0,1'b0, 5'd0, 1'b0,1'b0};

      rst_n = 1'b0;
      drive(v[10]);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         if (i > 0) @(negedge clk);
         drive(v[i]);
         #1;
         chk($sformatf("s%0d_SrcA", i), SrcA, v[i].e_srca);
         chk($sformatf("s%0d_WriteData", i), WriteData, v[i].e_wd);
         chk($sformatf("s%0d_ImmExt", i), ImmExt, v[i].e_imm);
         chk($sformatf("s%0d_ALUControl", i), 32'(ALUControl), 32'(v[i].e_alu));
         chk($sformatf("s%0d_funct3", i), 32'(funct3), 32'(v[i].e_f3));
         chk($sformatf("s%0d_ALUSrc", i), 32'(ALUSrc), 32'(v[i].e_as));
         chk($sformatf("s%0d_MemWrite", i), 32'(MemWrite), 32'(v[i].e_mw));
         chk($sformatf("s%0d_ex_valid", i), 32'(ex_valid), 32'(v[i].e_valid));
         chk($sformatf("s%0d_ex_reg_write", i), 32'(ex_reg_write), 32'(v[i].e_rw));
         chk($sformatf("s%0d_ex_mem_to_reg", i), 32'(ex_mem_to_reg), 32'(v[i].e_m2r));
         chk($sformatf("s%0d_ex_rd", i), 32'(ex_rd), 32'(v[i].e_rd));
         chk($sformatf("s%0d_fwd_a", i), 32'(fwd_a), 32'(v[i].e_fa));
         chk($sformatf("s%0d_fwd_b", i), 32'(fwd_b), 32'(v[i].e_fb));
      end
      @(negedge clk);
      chk("tail_bubble_valid", 32'(ex_valid), 32'd0);
`ifdef ID_EX_PERF_EN
      chk("table_perf_bubbles", perf_bubbles, 32'd3);
      chk("table_perf_holds", perf_holds, 32'd2);
`endif

      // Asynchronous reset in the middle of a cycle with a live instruction.
      drive(v[10]);
      id_valid = 1'b1; id_rs1 = 5'd1; id_rd = 5'd2; id_rs1_val = 32'h123;
      id_mem_write = 1'b1; id_reg_write = 1'b1;
      @(negedge clk);
      chk("pre_rst_valid", 32'(ex_valid), 32'd1);
      chk("pre_rst_SrcA", SrcA, 32'h123);
      chk("pre_rst_MemWrite", 32'(MemWrite), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(ex_valid), 32'd0);
      chk("rst_SrcA", SrcA, 32'h0);
      chk("rst_MemWrite", 32'(MemWrite), 32'd0);
      chk("rst_reg_write", 32'(ex_reg_write), 32'd0);
      chk("rst_rd", 32'(ex_rd), 32'd0);
`ifdef ID_EX_PERF_EN
      chk("rst_perf_bubbles", perf_bubbles, 32'd0);
      chk("rst_perf_holds", perf_holds, 32'd0);
`endif

      // Release, then three flush edges with hold and a store pending in Decode.
      @(negedge clk);
      rst_n = 1'b1;
      flush = 1'b1; hold = 1'b1; id_valid = 1'b1; id_mem_write = 1'b1; id_reg_write = 1'b1;
      repeat (3) @(negedge clk);
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_MemWrite", 32'(MemWrite), 32'd0);
      chk("flush_reg_write", 32'(ex_reg_write), 32'd0);
      chk("flush_SrcA", SrcA, 32'h0);
`ifdef ID_EX_PERF_EN
      chk("flush_perf_bubbles", perf_bubbles, 32'd3);
      chk("flush_perf_holds", perf_holds, 32'd0);
`endif

      flush = 1'b0; hold = 1'b0; id_valid = 1'b0;
      @(negedge clk);
      chk("idle_valid", 32'(ex_valid), 32'd0);
      chk("idle_MemWrite", 32'(MemWrite), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
